// File: rtl/alarm_controller.sv
// Minute-resolution alarm controller: watches the clock's sec/min counters for the
// hh:MM:00 instant, rings for a bounded number of second ticks, supports stop/snooze.
module alarm_controller #(
    parameter int unsigned RING_SECS   = 30,
    parameter int unsigned SNOOZE_MINS = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic       arm_en,
    input  logic       set_valid,
    input  logic [5:0] set_min,
    output logic       set_ready,
    output logic       set_err,
    input  logic       stop,
    input  logic       snooze,
    output logic       ringing,
    output logic [1:0] state,
    output logic [5:0] alarm_min
);

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        RINGING  = 2'd2,
        SNOOZE   = 2'd3
    } state_t;

    localparam logic [5:0] RING_LAST  = 6'(RING_SECS - 1);
    localparam logic [6:0] SNOOZE_OFS = 7'(SNOOZE_MINS);
    localparam logic [5:0] MIN_MAX    = 6'd59;

    // Minute addition modulo 60; the 7-bit sum never exceeds 59 + 59.
    function automatic logic [5:0] add_mod60(input logic [5:0] a, input logic [6:0] b);
        logic [6:0] sum;
        sum = {1'b0, a} + b;
        if (sum >= 7'd60) begin
            sum = sum - 7'd60;
        end
        return sum[5:0];
    endfunction

    state_t     state_q, state_d;
    logic [5:0] alarm_min_q, alarm_min_d;
    logic [5:0] snooze_min_q, snooze_min_d;
    logic [5:0] ring_cnt_q, ring_cnt_d;
    logic [5:0] sec_q;
    logic       ringing_q;
    logic       set_err_q, set_err_d;
    logic       set_ready_q;

    logic       tick;
    logic       match;
    logic [5:0] target;
    logic       accept;
    logic       wr_ok;

    always_comb begin
        tick   = (sec != sec_q);
        target = (state_q == SNOOZE) ? snooze_min_q : alarm_min_q;
        match  = tick && (sec == 6'd0) && (min == target);
        accept = set_valid && set_ready_q;
        wr_ok  = accept && (set_min <= MIN_MAX);

        state_d      = state_q;
        alarm_min_d  = wr_ok ? set_min : alarm_min_q;
        snooze_min_d = snooze_min_q;
        ring_cnt_d   = ring_cnt_q;
        set_err_d    = accept && (set_min > MIN_MAX);

        if (!arm_en) begin
            state_d = DISARMED;
        end else begin
            case (state_q)
                DISARMED: state_d = ARMED;
                // Match is evaluated against the pre-write alarm_min.
                ARMED: begin
                    if (match) begin
                        state_d    = RINGING;
                        ring_cnt_d = 6'd0;
                    end
                end
                RINGING: begin
                    if (stop) begin
                        state_d = ARMED;
                    end else if (snooze) begin
                        state_d      = SNOOZE;
                        snooze_min_d = add_mod60(min, SNOOZE_OFS);
                    end else if (tick) begin
                        if (ring_cnt_q == RING_LAST) begin
                            state_d = ARMED;
                        end else begin
                            ring_cnt_d = ring_cnt_q + 6'd1;
                        end
                    end
                end
                SNOOZE: begin
                    if (stop || wr_ok) begin
                        state_d = ARMED;
                    end else if (match) begin
                        state_d    = RINGING;
                        ring_cnt_d = 6'd0;
                    end
                end
                default: state_d = DISARMED;
            endcase
        end
    end

    // Outputs are registered from the next state so ringing/set_ready track state exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= DISARMED;
            alarm_min_q  <= 6'd0;
            snooze_min_q <= 6'd0;
            ring_cnt_q   <= 6'd0;
            sec_q        <= 6'd0;
            ringing_q    <= 1'b0;
            set_err_q    <= 1'b0;
            set_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            alarm_min_q  <= alarm_min_d;
            snooze_min_q <= snooze_min_d;
            ring_cnt_q   <= ring_cnt_d;
            sec_q        <= sec;
            ringing_q    <= (state_d == RINGING);
            set_err_q    <= set_err_d;
            set_ready_q  <= (state_d != RINGING);
        end
    end

    assign state     = state_q;
    assign alarm_min = alarm_min_q;
    assign ringing   = ringing_q;
    assign set_err   = set_err_q;
    assign set_ready = set_ready_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller: the clock counter advances one second every
// two clk cycles, so ticks and non-tick cycles alternate.
module tb_alarm_controller;

    logic       clk;
    logic       rst;
    logic [5:0] sec;
    logic [5:0] min;
    logic       arm_en;
    logic       set_valid;
    logic [5:0] set_min;
    logic       set_ready;
    logic       set_err;
    logic       stop;
    logic       snooze;
    logic       ringing;
    logic [1:0] state;
    logic [5:0] alarm_min;

    int n_cmp;
    int n_err;
    int cm;
    int cs;

    alarm_controller #(.RING_SECS(30), .SNOOZE_MINS(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .sec       (sec),
        .min       (min),
        .arm_en    (arm_en),
        .set_valid (set_valid),
        .set_min   (set_min),
        .set_ready (set_ready),
        .set_err   (set_err),
        .stop      (stop),
        .snooze    (snooze),
        .ringing   (ringing),
        .state     (state),
        .alarm_min (alarm_min)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_next();
        cs++;
        if (cs == 60) begin
            cs = 0;
            cm = (cm + 1) % 60;
        end
        sec = 6'(cs);
        min = 6'(cm);
    endtask

    task automatic adv();
        apply_next();
        clk1();
        clk1();
    endtask

    // Runs the counter forward until m:s is presented on the inputs, not yet clocked.
    task automatic run_to(input int m, input int s);
        int n;
        n = 0;
        apply_next();
        while (!(cm == m && cs == s) && n < 4000) begin
            clk1();
            clk1();
            apply_next();
            n++;
        end
        check("run_to_bound", (n < 4000) ? 8'd1 : 8'd0, 8'd1);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; cm = 0; cs = 0;
        rst = 1'b1; sec = 6'd0; min = 6'd0; arm_en = 1'b0;
        set_valid = 1'b0; set_min = 6'd0; stop = 1'b0; snooze = 1'b0;
        clk1();
        clk1();
        check("rst_state", 8'(state), 8'd0);
        check("rst_ringing", 8'(ringing), 8'd0);
        check("rst_set_ready", 8'(set_ready), 8'd1);
        check("rst_set_err", 8'(set_err), 8'd0);
        check("rst_alarm_min", 8'(alarm_min), 8'd0);
        rst = 1'b0;

        // Illegal write
        set_valid = 1'b1; set_min = 6'd61;
        clk1();
        set_valid = 1'b0;
        check("illegal_set_err", 8'(set_err), 8'd1);
        check("illegal_alarm_min", 8'(alarm_min), 8'd0);
        clk1();
        check("set_err_one_cycle", 8'(set_err), 8'd0);

        // Legal write while disarmed, then arm
        set_valid = 1'b1; set_min = 6'd2;
        clk1();
        set_valid = 1'b0;
        check("write2_alarm_min", 8'(alarm_min), 8'd2);
        check("still_disarmed", 8'(state), 8'd0);
        arm_en = 1'b1;
        clk1();
        check("armed", 8'(state), 8'd1);
        snooze = 1'b1;
        clk1();
        snooze = 1'b0;
        check("snooze_ignored", 8'(state), 8'd1);

        // Basic fire at 02:00 and 30-tick timeout
        run_to(2, 0);
        clk1();
        check("fire_ringing", 8'(ringing), 8'd1);
        check("fire_state", 8'(state), 8'd2);
        check("fire_set_ready", 8'(set_ready), 8'd0);
        clk1();
        repeat (29) adv();
        check("ring_after_29", 8'(ringing), 8'd1);
        apply_next();
        clk1();
        check("timeout_ringing", 8'(ringing), 8'd0);
        check("timeout_state", 8'(state), 8'd1);
        check("timeout_set_ready", 8'(set_ready), 8'd1);
        clk1();

        // Hourly re-fire, then stop
        run_to(2, 0);
        clk1();
        check("refire_ringing", 8'(ringing), 8'd1);
        clk1();
        stop = 1'b1;
        clk1();
        stop = 1'b0;
        check("stop_ringing", 8'(ringing), 8'd0);
        check("stop_state", 8'(state), 8'd1);
        run_to(3, 0);
        clk1();
        check("no_refire", 8'(state), 8'd1);

        // Simultaneous write and match
        set_valid = 1'b1; set_min = 6'd5;
        clk1();
        set_valid = 1'b0;
        check("write5", 8'(alarm_min), 8'd5);
        run_to(5, 0);
        set_valid = 1'b1; set_min = 6'd10;
        clk1();
        set_valid = 1'b0;
        check("wr_match_ringing", 8'(ringing), 8'd1);
        check("wr_match_alarm_min", 8'(alarm_min), 8'd10);
        clk1();
        stop = 1'b1;
        clk1();
        stop = 1'b0;
        check("wr_match_stop", 8'(state), 8'd1);

        // Write held while ringing is blocked until the ring ends
        run_to(10, 0);
        clk1();
        check("fire10_ringing", 8'(ringing), 8'd1);
        set_valid = 1'b1; set_min = 6'd20;
        clk1();
        check("blocked_ready", 8'(set_ready), 8'd0);
        check("blocked_alarm_min", 8'(alarm_min), 8'd10);
        repeat (29) adv();
        check("blocked_alarm_min_late", 8'(alarm_min), 8'd10);
        apply_next();
        clk1();
        check("unblock_state", 8'(state), 8'd1);
        check("unblock_ready", 8'(set_ready), 8'd1);
        check("unblock_alarm_min", 8'(alarm_min), 8'd10);
        clk1();
        set_valid = 1'b0;
        check("late_write_alarm_min", 8'(alarm_min), 8'd20);

        // Snooze across the hour wrap: 57 + 5 -> 02
        set_valid = 1'b1; set_min = 6'd57;
        clk1();
        set_valid = 1'b0;
        check("write57", 8'(alarm_min), 8'd57);
        run_to(57, 0);
        clk1();
        check("fire57_ringing", 8'(ringing), 8'd1);
        clk1();
        snooze = 1'b1;
        clk1();
        snooze = 1'b0;
        check("snooze_state", 8'(state), 8'd3);
        check("snooze_ringing", 8'(ringing), 8'd0);
        check("snooze_set_ready", 8'(set_ready), 8'd1);
        run_to(1, 59);
        clk1();
        check("snooze_hold", 8'(state), 8'd3);
        clk1();
        apply_next();
        clk1();
        check("snooze_resume_ringing", 8'(ringing), 8'd1);
        check("snooze_resume_state", 8'(state), 8'd2);

        // Disarm mid-ring
        clk1();
        arm_en = 1'b0;
        clk1();
        check("disarm_state", 8'(state), 8'd0);
        check("disarm_ringing", 8'(ringing), 8'd0);
        check("disarm_set_ready", 8'(set_ready), 8'd1);
        arm_en = 1'b1;
        clk1();
        check("rearm_state", 8'(state), 8'd1);

        // Reset mid-ring
        set_valid = 1'b1; set_min = 6'd3;
        clk1();
        set_valid = 1'b0;
        check("write3", 8'(alarm_min), 8'd3);
        run_to(3, 0);
        clk1();
        check("fire3_ringing", 8'(ringing), 8'd1);
        rst = 1'b1;
        clk1();
        check("midrst_state", 8'(state), 8'd0);
        check("midrst_ringing", 8'(ringing), 8'd0);
        check("midrst_set_ready", 8'(set_ready), 8'd1);
        check("midrst_alarm_min", 8'(alarm_min), 8'd0);
        check("midrst_set_err", 8'(set_err), 8'd0);
        rst = 1'b0;
        clk1();
        check("post_rst_armed", 8'(state), 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
